// File: rtl/datapath_pkg.sv
// ============================================================================
// datapath_pkg : shared types, bus-source indices and helpers for datapath_p
// Revision: 1.0
// ============================================================================
`default_nettype none

package datapath_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RD   = 2'd1,
        MS_WR   = 2'd2
    } mem_state_t;

    // Bus source indices, listed in falling priority order
    localparam int SRC_REG = 0;
    localparam int SRC_HI  = 1;
    localparam int SRC_LO  = 2;
    localparam int SRC_ZHI = 3;
    localparam int SRC_ZLO = 4;
    localparam int SRC_PC  = 5;
    localparam int SRC_MDR = 6;
    localparam int SRC_IN  = 7;
    localparam int SRC_C   = 8;
    localparam int NSRC    = 9;

    // Sign-extends the low w bits of v to 64 bits; callers truncate to their width
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
        logic [63:0] sh;
        sh = v << (64 - w);
        return $signed(sh) >>> (64 - w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_if_fsm.sv
// ============================================================================
// mem_if_fsm : handshaked memory request FSM with wait-count timeout
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_if_fsm
    import datapath_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    output logic              mdr_capture,
    output logic              mdr_lock
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    mem_state_t       state, state_nx;
    logic [CNT_W-1:0] wait_cnt;
    logic             start, ack_hit, timeout;

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        ack_hit  = 1'b0;
        timeout  = 1'b0;
        case (state)
            MS_IDLE: begin
                if (read) begin
                    state_nx = MS_RD;
                    start    = 1'b1;
                end else if (write) begin
                    state_nx = MS_WR;
                    start    = 1'b1;
                end
            end
            MS_RD, MS_WR: begin
                // An ack arriving on the final wait cycle still completes the access
                if (mem_ack) begin
                    ack_hit  = 1'b1;
                    state_nx = MS_IDLE;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                    timeout  = 1'b1;
                    state_nx = MS_IDLE;
                end
            end
            default: state_nx = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= MS_IDLE;
            wait_cnt <= '0;
            mem_addr <= '0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_done <= ack_hit;
            if (timeout) begin
                mem_err <= 1'b1;
            end
            if (start) begin
                mem_addr <= mar_addr;
                wait_cnt <= '0;
            end else if (state != MS_IDLE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign mem_rd      = (state == MS_RD);
    assign mem_wr      = (state == MS_WR);
    assign mem_busy    = (state != MS_IDLE);
    assign mdr_capture = (state == MS_RD) && mem_ack;
    assign mdr_lock    = (state == MS_WR);

endmodule

`default_nettype wire

// File: rtl/datapath_p.sv
// ============================================================================
// datapath_p : parametrised register-transfer datapath with register file,
//              priority bus, external ALU ports and handshaked memory port
// Revision: 1.0
// ============================================================================
`default_nettype none

module datapath_p
    import datapath_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NREGS       = 16,
    parameter int ADDR_W      = 9,
    parameter int C_W         = 19,
    parameter int PC_STEP     = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [$clog2(NREGS)-1:0] reg_sel,
    input  logic                     reg_in,
    input  logic                     reg_out,
    input  logic                     BA_out,
    input  logic                     PC_in,
    input  logic                     PC_inc,
    input  logic                     IR_in,
    input  logic                     Y_in,
    input  logic                     Z_in,
    input  logic                     HI_in,
    input  logic                     LO_in,
    input  logic                     MAR_in,
    input  logic                     MDR_in,
    input  logic                     Out_in,
    input  logic                     PC_out,
    input  logic                     Zhigh_out,
    input  logic                     Zlow_out,
    input  logic                     HI_out,
    input  logic                     LO_out,
    input  logic                     MDR_out,
    input  logic                     InPort_out,
    input  logic                     C_out,
    input  logic                     Read,
    input  logic                     Write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    output logic                     mem_rd,
    output logic                     mem_wr,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    output logic                     mem_busy,
    output logic                     mem_done,
    output logic                     mem_err,
    input  logic [WIDTH-1:0]         InPort_Data,
    output logic [WIDTH-1:0]         OutPort_Data,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    input  logic [WIDTH-1:0]         alu_hi,
    input  logic [WIDTH-1:0]         alu_lo,
    output logic [WIDTH-1:0]         Bus_Data,
    output logic                     bus_err,
    output logic [WIDTH-1:0]         IR_Data,
    output logic [WIDTH-1:0]         PC_Data
);

    localparam int SEL_W = $clog2(NREGS);

    logic [WIDTH-1:0]  rf [NREGS];
    logic [WIDTH-1:0]  pc, ir, y, zhi, zlo, hi, lo, mdr, outport, bus, c_ext;
    logic [ADDR_W-1:0] mar;
    logic [NSRC-1:0]   src_en;
    logic              mdr_capture, mdr_lock;

    for (genvar i = 0; i < NREGS; i++) begin : g_regs
        logic [WIDTH-1:0] r;
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r <= '0;
            end else if (reg_in && (reg_sel == SEL_W'(i))) begin
                r <= bus;
            end
        end
        assign rf[i] = r;
    end

    assign c_ext = WIDTH'(sign_ext(64'(ir[C_W-1:0]), C_W));

    always_comb begin
        src_en          = '0;
        src_en[SRC_REG] = reg_out;
        src_en[SRC_HI]  = HI_out;
        src_en[SRC_LO]  = LO_out;
        src_en[SRC_ZHI] = Zhigh_out;
        src_en[SRC_ZLO] = Zlow_out;
        src_en[SRC_PC]  = PC_out;
        src_en[SRC_MDR] = MDR_out;
        src_en[SRC_IN]  = InPort_out;
        src_en[SRC_C]   = C_out;

        bus = '0;
        if (reg_out)         bus = (BA_out && (reg_sel == '0)) ? '0 : rf[reg_sel];
        else if (HI_out)     bus = hi;
        else if (LO_out)     bus = lo;
        else if (Zhigh_out)  bus = zhi;
        else if (Zlow_out)   bus = zlo;
        else if (PC_out)     bus = pc;
        else if (MDR_out)    bus = mdr;
        else if (InPort_out) bus = InPort_Data;
        else if (C_out)      bus = c_ext;
    end

    // Clearing the lowest set bit leaves a nonzero value only if two or more sources are on
    assign bus_err = |(src_en & (src_en - 1'b1));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc      <= '0;
            ir      <= '0;
            y       <= '0;
            zhi     <= '0;
            zlo     <= '0;
            hi      <= '0;
            lo      <= '0;
            mar     <= '0;
            outport <= '0;
        end else begin
            if (PC_in)       pc <= bus;
            else if (PC_inc) pc <= pc + WIDTH'(PC_STEP);
            if (IR_in)       ir <= bus;
            if (Y_in)        y  <= bus;
            if (HI_in)       hi <= bus;
            if (LO_in)       lo <= bus;
            if (MAR_in)      mar <= bus[ADDR_W-1:0];
            if (Out_in)      outport <= bus;
            if (Z_in) begin
                zhi <= alu_hi;
                zlo <= alu_lo;
            end
        end
    end

    // Read capture wins over MDR_in; during a write MDR is frozen
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mdr <= '0;
        end else if (mdr_capture) begin
            mdr <= mem_rdata;
        end else if (MDR_in && !mdr_lock) begin
            mdr <= bus;
        end
    end

    mem_if_fsm #(
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_if (
        .clk         (clk),
        .clr         (clr),
        .read        (Read),
        .write       (Write),
        .mar_addr    (mar),
        .mem_ack     (mem_ack),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_busy    (mem_busy),
        .mem_done    (mem_done),
        .mem_err     (mem_err),
        .mdr_capture (mdr_capture),
        .mdr_lock    (mdr_lock)
    );

    assign Bus_Data     = bus;
    assign alu_a        = y;
    assign alu_b        = bus;
    assign mem_wdata    = mdr;
    assign OutPort_Data = outport;
    assign IR_Data      = ir;
    assign PC_Data      = pc;

endmodule

`default_nettype wire

// File: tb/tb_datapath_p.sv
// ============================================================================
// tb_datapath_p : scoreboard bench for datapath_p with directed vectors
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_datapath_p;

    localparam int W = 32;
    localparam int T = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clr;
    logic [3:0]   reg_sel;
    logic         reg_in, reg_out, BA_out, PC_in, PC_inc, IR_in, Y_in, Z_in, HI_in, LO_in;
    logic         MAR_in, MDR_in, Out_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out;
    logic         MDR_out, InPort_out, C_out, Read, Write, mem_ack;
    logic [W-1:0] mem_rdata, InPort_Data, alu_hi, alu_lo;
    logic [8:0]   mem_addr;
    logic [W-1:0] mem_wdata, OutPort_Data, alu_a, alu_b, Bus_Data, IR_Data, PC_Data;
    logic         mem_rd, mem_wr, mem_busy, mem_done, mem_err, bus_err;

    datapath_p dut (
        .clk(clk), .clr(clr), .reg_sel(reg_sel), .reg_in(reg_in), .reg_out(reg_out),
        .BA_out(BA_out), .PC_in(PC_in), .PC_inc(PC_inc), .IR_in(IR_in), .Y_in(Y_in),
        .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
        .Out_in(Out_in), .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out),
        .HI_out(HI_out), .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out),
        .C_out(C_out), .Read(Read), .Write(Write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
        .InPort_Data(InPort_Data), .OutPort_Data(OutPort_Data), .alu_a(alu_a),
        .alu_b(alu_b), .alu_hi(alu_hi), .alu_lo(alu_lo), .Bus_Data(Bus_Data),
        .bus_err(bus_err), .IR_Data(IR_Data), .PC_Data(PC_Data)
    );

    typedef enum int {
        S_BUS, S_BERR, S_PC, S_MDR, S_MADDR, S_MRD, S_MWR,
        S_MBUSY, S_MERR, S_MDONE, S_OUT, S_ALUA, S_ALUB
    } sig_t;

    typedef struct {
        sig_t        sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] mdr;
        logic [8:0]  addr;
    } done_t;

    exp_t  exp_q[$];
    done_t done_q[$];
    int    total  = 0;
    int    passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [31:0] probe(input sig_t s);
        case (s)
            S_BUS:   return Bus_Data;
            S_BERR:  return 32'(bus_err);
            S_PC:    return PC_Data;
            S_MDR:   return mem_wdata;
            S_MADDR: return 32'(mem_addr);
            S_MRD:   return 32'(mem_rd);
            S_MWR:   return 32'(mem_wr);
            S_MBUSY: return 32'(mem_busy);
            S_MERR:  return 32'(mem_err);
            S_MDONE: return 32'(mem_done);
            S_OUT:   return OutPort_Data;
            S_ALUA:  return alu_a;
            S_ALUB:  return alu_b;
            default: return 32'hx;
        endcase
    endfunction

    // Monitor: completions pop the done scoreboard, queued expectations are drained each cycle
    always @(negedge clk) begin : monitor
        done_t d;
        exp_t  e;
        if (mem_done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(mem_done), 32'd0);
            end else begin
                d = done_q.pop_front();
                check("done_mdr", mem_wdata, d.mdr);
                check("done_addr", 32'(mem_addr), 32'(d.addr));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, probe(e.sig), e.val);
        end
    end

    task automatic expv(input sig_t s, input logic [31:0] v, input string n);
        exp_q.push_back('{sig: s, val: v, name: n});
    endtask

    task automatic expdone(input logic [31:0] m, input logic [8:0] a);
        done_q.push_back('{mdr: m, addr: a});
    endtask

    task automatic clear_ctl();
        reg_sel = '0; reg_in = 0; reg_out = 0; BA_out = 0; PC_in = 0; PC_inc = 0;
        IR_in = 0; Y_in = 0; Z_in = 0; HI_in = 0; LO_in = 0; MAR_in = 0; MDR_in = 0;
        Out_in = 0; PC_out = 0; Zhigh_out = 0; Zlow_out = 0; HI_out = 0; LO_out = 0;
        MDR_out = 0; InPort_out = 0; C_out = 0; Read = 0; Write = 0; mem_ack = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    initial begin
        clr = 1'b0;
        clear_ctl();
        InPort_Data = '0; mem_rdata = '0; alu_hi = '0; alu_lo = '0;

        step();
        expv(S_PC, 0, "rst_pc"); expv(S_MDR, 0, "rst_mdr"); expv(S_MBUSY, 0, "rst_busy");
        expv(S_MERR, 0, "rst_err"); expv(S_MDONE, 0, "rst_done"); expv(S_OUT, 0, "rst_outport");
        expv(S_BUS, 0, "rst_bus"); expv(S_MRD, 0, "rst_mem_rd");
        step(); clr = 1'b1;

        // Register file write/read and base-address mode
        step(); reg_sel = 3; reg_in = 1; InPort_out = 1; InPort_Data = 32'hDEADBEEF;
        expv(S_BUS, 32'hDEADBEEF, "bus_inport");
        step(); reg_sel = 3; reg_out = 1;
        expv(S_BUS, 32'hDEADBEEF, "r3_read"); expv(S_BERR, 0, "r3_no_contention");
        step(); reg_sel = 0; reg_in = 1; InPort_out = 1; InPort_Data = 32'h0000_1234;
        step(); reg_sel = 0; reg_out = 1; BA_out = 1;
        expv(S_BUS, 0, "ba_r0_zero");
        step(); reg_sel = 0; reg_out = 1;
        expv(S_BUS, 32'h0000_1234, "r0_stored");
        step(); reg_sel = 0; reg_out = 1; PC_out = 1;
        expv(S_BUS, 32'h0000_1234, "contention_bus"); expv(S_BERR, 1, "contention_err");

        // PC wrap and PC_in priority over PC_inc
        step(); InPort_out = 1; InPort_Data = 32'hFFFF_FFFF; PC_in = 1;
        step(); PC_inc = 1;
        expv(S_PC, 32'hFFFF_FFFF, "pc_load");
        step(); expv(S_PC, 0, "pc_wrap");
        step(); InPort_out = 1; InPort_Data = 32'h40; PC_in = 1; PC_inc = 1;
        step(); expv(S_PC, 32'h40, "pc_in_priority");

        // Y / Z / HI / LO paths
        step(); InPort_out = 1; InPort_Data = 32'h77; Y_in = 1; Z_in = 1;
        alu_hi = 32'hAAAA_0000; alu_lo = 32'h0000_5555;
        step(); Zhigh_out = 1;
        expv(S_ALUA, 32'h77, "y_to_alu_a"); expv(S_BUS, 32'hAAAA_0000, "zhigh_bus");
        expv(S_ALUB, 32'hAAAA_0000, "alu_b_is_bus");
        step(); Zlow_out = 1;
        expv(S_BUS, 32'h0000_5555, "zlow_bus");
        step(); InPort_out = 1; InPort_Data = 32'h1111; HI_in = 1;
        step(); HI_out = 1; LO_out = 1;
        expv(S_BUS, 32'h1111, "hi_over_lo"); expv(S_BERR, 1, "hi_lo_contention");

        // Output port and sign-extended immediate
        step(); InPort_out = 1; InPort_Data = 32'hA5A5; Out_in = 1;
        step(); expv(S_OUT, 32'hA5A5, "outport_load");
        step(); InPort_out = 1; InPort_Data = 32'h0004_0001; IR_in = 1;
        step(); C_out = 1;
        expv(S_BUS, 32'hFFFC_0001, "c_sign_ext");

        // Read with ack on the third request cycle
        step(); InPort_out = 1; InPort_Data = 32'h0000_F1A5; MAR_in = 1;
        step(); Read = 1; expdone(32'h1234_5678, 9'h1A5);
        step(); expv(S_MRD, 1, "rd_level"); expv(S_MADDR, 32'h1A5, "rd_addr");
        expv(S_MBUSY, 1, "rd_busy");
        step();
        step(); mem_ack = 1; mem_rdata = 32'h1234_5678;
        step();
        expv(S_MRD, 0, "rd_released"); expv(S_MBUSY, 0, "rd_not_busy");
        expv(S_MDR, 32'h1234_5678, "rd_mdr"); expv(S_MDONE, 1, "rd_done_pulse");
        step(); expv(S_MDONE, 0, "rd_done_single");

        // Write timeout; MDR_in during the write must be ignored
        step(); Write = 1;
        step(); expv(S_MWR, 1, "wr_level");
        MDR_in = 1; InPort_out = 1; InPort_Data = 32'h0BAD;
        for (int i = 1; i <= T + 1; i++) begin
            step();
            if (i == T) expv(S_MERR, 0, "err_not_early");
            if (i == T + 1) begin
                expv(S_MERR, 1, "err_timeout"); expv(S_MBUSY, 0, "timeout_idle");
                expv(S_MDR, 32'h1234_5678, "wr_mdr_locked");
            end
        end

        // Minimum-latency read after the error; error stays sticky
        step(); Read = 1; expdone(32'hCAFE_F00D, 9'h1A5);
        step(); mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        expv(S_MRD, 1, "fast_rd_level");
        step();
        expv(S_MDR, 32'hCAFE_F00D, "fast_rd_mdr"); expv(S_MERR, 1, "err_sticky");
        expv(S_MDONE, 1, "fast_rd_done");

        // Read and Write together; ack capture beats MDR_in
        step(); Read = 1; Write = 1; expdone(32'h0F0F_0F0F, 9'h1A5);
        step(); expv(S_MRD, 1, "rw_read_wins"); expv(S_MWR, 0, "rw_no_write");
        mem_ack = 1; mem_rdata = 32'h0F0F_0F0F;
        MDR_in = 1; InPort_out = 1; InPort_Data = 32'h111;
        step(); expv(S_MDR, 32'h0F0F_0F0F, "ack_beats_mdr_in");

        // Asynchronous clear mid-read; late ack ignored
        step(); Read = 1;
        step(); expv(S_MRD, 1, "pre_clr_rd");
        step(); clr = 1'b0;
        expv(S_MRD, 0, "clr_drop_rd"); expv(S_MBUSY, 0, "clr_drop_busy");
        step(); clr = 1'b1;
        step(); mem_ack = 1; mem_rdata = 32'h55;
        step(); expv(S_MDR, 0, "late_ack_mdr"); expv(S_MDONE, 0, "late_ack_no_done");
        expv(S_MRD, 0, "late_ack_idle");
        step();
        step();
        check("done_queue_empty", 32'(done_q.size()), 32'd0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
